gate_resp_checker: RTL and testbench
====================================

Name: gate_resp_checker

Overview:
- Synthesizable response-side checker for two-input gate tests; the counterpart to the stimulus driver in gate testbenches.
- Samples the DUT output for each applied (a,b) vector and compares it with a programmable 4-entry truth table.
- Counts vectors, mismatches and input-space coverage, captures the first failing vector, and reports pass/fail.
- Sits between the stimulus source and the DUT output, so NAND, AND and OR cells can be self-checked without $monitor.

Parameters:
- NUM_VEC, 4, samples accepted per run before DONE; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of vec_cnt and err_cnt.
- TMO_CYC, 255, idle cycles in RUN with no sample before timeout; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a run.
- truth_tbl  in  4  expected output, indexed by {a,b}; bit0 = a0b0, bit3 = a1b1.
- smp_valid  in  1  the sample on smp_a/smp_b/smp_x is valid this cycle.
- smp_a  in  1  applied input A.
- smp_b  in  1  applied input B.
- smp_x  in  1  observed DUT output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high.
- timeout  out  1  the run ended by timeout.
- vec_cnt  out  CNT_W  samples accepted this run.
- err_cnt  out  CNT_W  mismatches; saturates at all-ones.
- cov  out  4  coverage bitmap; bit {a,b} is set once that vector is seen.
- ff_valid  out  1  first_fail holds a captured vector.
- first_fail  out  2  {a,b} of the first mismatch.

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs 0.
- All outputs are registered.
- States are IDLE, RUN and DONE.
- IDLE:
  - start -> RUN.
  - On entry to RUN, clear vec_cnt, err_cnt, cov, ff_valid, first_fail, timeout and the idle timer.
- RUN, on smp_valid:
  - exp = truth_tbl[{smp_a,smp_b}].
  - vec_cnt increments.
  - cov[{a,b}] is set.
  - If smp_x != exp: err_cnt increments (saturating). If ff_valid = 0, capture first_fail = {a,b} and set ff_valid = 1.
  - The idle timer clears.
- RUN, no sample: the idle timer increments.
- RUN transitions:
  - When the accepted sample makes vec_cnt = NUM_VEC -> DONE. done rises the cycle after that sample is registered, i.e. 1-cycle latency.
  - If TMO_CYC != 0 and the idle timer reaches TMO_CYC -> DONE with timeout = 1.
- DONE:
  - pass = (err_cnt == 0) and (cov == 4'hF) and !timeout; pass is computed at the DONE transition.
  - Counters hold.
  - start -> RUN with counters cleared.
- Ignored inputs: smp_valid in IDLE or DONE; truth_tbl changes take effect on the next sample.
- start while in RUN: restart; clear everything and stay in RUN.
- start and smp_valid in the same cycle: start wins and the sample is discarded.
- Repeated vectors are counted in vec_cnt but add no new coverage. If NUM_VEC = 4 and a vector repeats, cov != F and pass = 0.
- rst_n low mid-run: immediate return to IDLE with all outputs 0; no partial result is retained.
- err_cnt at all-ones stays all-ones. vec_cnt cannot overflow because NUM_VEC < 2**CNT_W.

Decomposition:
- Package gate_test_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Truth-table constants: TT_NAND = 4'b0111, TT_AND = 4'b1000, TT_OR = 4'b1110, TT_NOR = 4'b0001, TT_XOR = 4'b0110.
- Sub-module: sat_counter (width parameter; clear, inc, saturate) used for err_cnt. vec_cnt and the idle timer are plain counters inline.

Test Plan:
1. truth_tbl = TT_NAND; start; samples 00->1, 01->1, 10->1, 11->0 -> done next cycle; pass = 1, err_cnt = 0, cov = F, vec_cnt = 4, ff_valid = 0.
2. TT_NAND; samples 00->1, 01->1, 10->0, 11->1 -> err_cnt = 2, ff_valid = 1, first_fail = 2'b10, pass = 0.
3. TT_NAND; samples 00, 01, 01, 11, all correct -> cov = 4'b1011, vec_cnt = 4, err_cnt = 0, pass = 0.
4. TMO_CYC = 10; start; one sample, then idle -> done 10 cycles after the last sample; timeout = 1, pass = 0, vec_cnt = 1.
5. NUM_VEC = 255, CNT_W = 8; 255 wrong samples -> err_cnt = 8'hFF with no wrap; first_fail = first vector sent.
6. Mid-run rst_n pulse after 2 samples -> all outputs 0 and IDLE. start with smp_valid in the same cycle -> sample discarded, vec_cnt = 0.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared types and constants for two-input gate response checking.
package gate_test_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Truth tables indexed by {a,b}: bit0 = a0b0 ... bit3 = a1b1.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic tt_lookup(logic [3:0] tbl, logic a, logic b);
    return tbl[{a, b}];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear has priority; increment stops once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gate_resp_checker.sv
// Response-side checker: compares sampled gate outputs against a 4-entry
// truth table, tracks counts and input coverage, and reports pass/fail.
module gate_resp_checker
  import gate_test_pkg::*;
#(
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       truth_tbl,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             ff_valid,
  output logic [1:0]       first_fail
);

  localparam int unsigned TMR_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(TMO_CYC);
  localparam logic [CNT_W-1:0] VEC_LIM = CNT_W'(NUM_VEC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [3:0]       cov_q, cov_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       ff_q, ff_d;
  logic             tmo_q, tmo_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic [1:0] smp_idx;
  logic       accept;
  logic       mismatch;
  logic       to_done;

  // A sample only counts in RUN and never in the same cycle as start.
  assign smp_idx  = {smp_a, smp_b};
  assign accept   = (state_q == RUN) && smp_valid && !start;
  assign mismatch = accept && (smp_x != tt_lookup(truth_tbl, smp_a, smp_b));

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (mismatch),
    .cnt   (err_cnt)
  );

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ff_d    = ff_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tmr_d   = tmr_q;
    to_done = 1'b0;

    if (start) begin
      // Start from any state (including RUN) begins a fresh run.
      state_d = RUN;
      vec_d   = '0;
      cov_d   = '0;
      ffv_d   = 1'b0;
      ff_d    = '0;
      tmo_d   = 1'b0;
      pass_d  = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      tmr_d   = '0;
    end else if (state_q == RUN) begin
      if (accept) begin
        vec_d          = vec_q + CNT_W'(1);
        cov_d[smp_idx] = 1'b1;
        tmr_d          = '0;
        if (mismatch && !ffv_q) begin
          ffv_d = 1'b1;
          ff_d  = smp_idx;
        end
        if (vec_d == VEC_LIM) begin
          to_done = 1'b1;
        end
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
        if ((TMO_CYC != 0) && (tmr_d == TMO_LIM)) begin
          to_done = 1'b1;
          tmo_d   = 1'b1;
        end
      end

      if (to_done) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // Saturating err_cnt can never return to zero, so this is its next value test.
        pass_d  = (err_cnt == '0) && !mismatch && (cov_d == 4'hF) && !tmo_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cov_q   <= '0;
      ffv_q   <= 1'b0;
      ff_q    <= '0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ff_q    <= ff_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmr_q   <= tmr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = tmo_q;
  assign vec_cnt    = vec_q;
  assign cov        = cov_q;
  assign ff_valid   = ffv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: stimulus pushes the expected end-of-run
// result, per-instance monitors pop and compare when done rises.
module tb_gate_resp_checker;

  localparam logic [3:0] T_NAND = 4'b0111;
  localparam logic [3:0] T_AND  = 4'b1000;
  localparam logic [3:0] T_ANB  = 4'b0100;  // a & !b, asymmetric in a/b

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [3:0] tt = 4'h0;
  logic       sa = 1'b0, sb = 1'b0, sx = 1'b0;

  logic       busy_a, done_a, pass_a, tmo_a, ffv_a;
  logic [7:0] vc_a, ec_a;
  logic [3:0] cov_a;
  logic [1:0] ff_a;
  logic       busy_b, done_b, pass_b, tmo_b, ffv_b;
  logic [7:0] vc_b, ec_b;
  logic [3:0] cov_b;
  logic [1:0] ff_b;

  gate_resp_checker #(.NUM_VEC(4), .CNT_W(8), .TMO_CYC(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .truth_tbl(tt), .smp_valid(valid_a),
    .smp_a(sa), .smp_b(sb), .smp_x(sx), .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(tmo_a), .vec_cnt(vc_a), .err_cnt(ec_a), .cov(cov_a), .ff_valid(ffv_a),
    .first_fail(ff_a)
  );

  gate_resp_checker #(.NUM_VEC(255), .CNT_W(8), .TMO_CYC(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .truth_tbl(tt), .smp_valid(valid_b),
    .smp_a(sa), .smp_b(sb), .smp_x(sx), .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(tmo_b), .vec_cnt(vc_b), .err_cnt(ec_b), .cov(cov_b), .ff_valid(ffv_b),
    .first_fail(ff_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pass;
    logic       tmo;
    logic [7:0] vc;
    logic [7:0] ec;
    logic [3:0] cov;
    logic       ffv;
    logic [1:0] ff;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit inst_b, input logic p, input logic t, input logic [7:0] vc,
                      input logic [7:0] ec, input logic [3:0] cv, input logic fv,
                      input logic [1:0] ff, input int c);
    exp_t e;
    e.pass = p; e.tmo = t; e.vc = vc; e.ec = ec; e.cov = cv; e.ffv = fv; e.ff = ff; e.cyc = c;
    if (inst_b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  // Monitor A: compare the queued result on each rising edge of done.
  logic done_a_prev = 1'b0;
  exp_t ea;
  always @(negedge clk) begin
    if (done_a && !done_a_prev) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'(done_a), 32'd0);
      end else begin
        ea = q_a.pop_front();
        chk("a_done_cycle", cyc, ea.cyc);
        chk("a_pass", 32'(pass_a), 32'(ea.pass));
        chk("a_timeout", 32'(tmo_a), 32'(ea.tmo));
        chk("a_vec_cnt", 32'(vc_a), 32'(ea.vc));
        chk("a_err_cnt", 32'(ec_a), 32'(ea.ec));
        chk("a_cov", 32'(cov_a), 32'(ea.cov));
        chk("a_ff_valid", 32'(ffv_a), 32'(ea.ffv));
        chk("a_first_fail", 32'(ff_a), 32'(ea.ff));
        chk("a_busy_low", 32'(busy_a), 32'd0);
      end
    end
    done_a_prev <= done_a;
  end

  // Monitor B: same scheme for the long-run instance.
  logic done_b_prev = 1'b0;
  exp_t eb;
  always @(negedge clk) begin
    if (done_b && !done_b_prev) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'(done_b), 32'd0);
      end else begin
        eb = q_b.pop_front();
        chk("b_done_cycle", cyc, eb.cyc);
        chk("b_pass", 32'(pass_b), 32'(eb.pass));
        chk("b_timeout", 32'(tmo_b), 32'(eb.tmo));
        chk("b_vec_cnt", 32'(vc_b), 32'(eb.vc));
        chk("b_err_cnt", 32'(ec_b), 32'(eb.ec));
        chk("b_cov", 32'(cov_b), 32'(eb.cov));
        chk("b_ff_valid", 32'(ffv_b), 32'(eb.ffv));
        chk("b_first_fail", 32'(ff_b), 32'(eb.ff));
      end
    end
    done_b_prev <= done_b;
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input bit inst_b, input logic st, input logic v, input logic [1:0] ab,
                      input logic x);
    if (inst_b) begin start_b = st; valid_b = v; end
    else begin start_a = st; valid_a = v; end
    sa = ab[1]; sb = ab[0]; sx = x;
    @(posedge clk); #1;
    start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input bit inst_b, input string name, input int budget);
    int k = 0;
    while (!(inst_b ? done_b : done_a) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(inst_b ? done_b : done_a), 32'd1);
  endtask

  function automatic logic [31:0] all_out_a();
    return {12'd0, busy_a, done_a, pass_a, tmo_a, vc_a, ec_a} | {cov_a, ffv_a, ff_a, 25'd0};
  endfunction

  function automatic logic [31:0] all_out_b();
    return {12'd0, busy_b, done_b, pass_b, tmo_b, vc_b, ec_b} | {cov_b, ffv_b, ff_b, 25'd0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] tbl;
    logic [1:0] idx;

    // Reset state
    #3;
    chk("reset_a_outputs", all_out_a(), 32'd0);
    chk("reset_b_outputs", all_out_b(), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("idle_a_outputs", all_out_a(), 32'd0);
    chk("idle_b_outputs", all_out_b(), 32'd0);

    // T1: NAND, all correct -> pass
    tt = T_NAND;
    step(0, 1, 0, 2'b00, 0);
    chk("t1_busy", 32'(busy_a), 32'd1);
    step(0, 0, 1, 2'b00, 1);
    step(0, 0, 1, 2'b01, 1);
    step(0, 0, 1, 2'b10, 1);
    push(0, 1, 0, 8'd4, 8'd0, 4'hF, 0, 2'b00, cyc + 1);
    step(0, 0, 1, 2'b11, 0);
    wait_done(0, "t1_done", 20);
    // Samples in DONE are ignored
    step(0, 0, 1, 2'b00, 0);
    chk("done_ignores_vec", 32'(vc_a), 32'd4);
    chk("done_ignores_err", 32'(ec_a), 32'd0);
    chk("done_holds", 32'(done_a), 32'd1);

    // T2: two mismatches, first at {1,0}
    step(0, 1, 0, 2'b00, 0);
    step(0, 0, 1, 2'b00, 1);
    step(0, 0, 1, 2'b01, 1);
    step(0, 0, 1, 2'b10, 0);
    push(0, 0, 0, 8'd4, 8'd2, 4'hF, 1, 2'b10, cyc + 1);
    step(0, 0, 1, 2'b11, 1);
    wait_done(0, "t2_done", 20);

    // T3: repeated vector, incomplete coverage
    step(0, 1, 0, 2'b00, 0);
    step(0, 0, 1, 2'b00, 1);
    step(0, 0, 1, 2'b01, 1);
    step(0, 0, 1, 2'b01, 1);
    push(0, 0, 0, 8'd4, 8'd0, 4'b1011, 0, 2'b00, cyc + 1);
    step(0, 0, 1, 2'b11, 0);
    wait_done(0, "t3_done", 20);

    // T7: asymmetric table checks the {a,b} index order
    tt = T_ANB;
    step(0, 1, 0, 2'b00, 0);
    step(0, 0, 1, 2'b00, 0);
    step(0, 0, 1, 2'b01, 0);
    step(0, 0, 1, 2'b10, 1);
    push(0, 1, 0, 8'd4, 8'd0, 4'hF, 0, 2'b00, cyc + 1);
    step(0, 0, 1, 2'b11, 0);
    wait_done(0, "t7_done", 20);

    // T4: one sample then idle -> timeout 10 cycles later
    tt = T_NAND;
    step(0, 1, 0, 2'b00, 0);
    push(0, 0, 1, 8'd1, 8'd0, 4'b0001, 0, 2'b00, cyc + 1 + 10);
    step(0, 0, 1, 2'b00, 1);
    wait_done(0, "t4_done", 30);

    // T6: mid-run reset clears everything
    step(0, 1, 0, 2'b00, 0);
    step(0, 0, 1, 2'b00, 1);
    step(0, 0, 1, 2'b10, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_async", all_out_a(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    chk("t6_reset_release", all_out_a(), 32'd0);
    // start with a sample in the same cycle: sample discarded
    step(0, 1, 1, 2'b11, 1);
    chk("t6_start_busy", 32'(busy_a), 32'd1);
    chk("t6_start_discard_vec", 32'(vc_a), 32'd0);
    chk("t6_start_discard_err", 32'(ec_a), 32'd0);
    // restart while running
    step(0, 0, 1, 2'b00, 0);
    step(0, 0, 1, 2'b01, 1);
    chk("t6_mid_err", 32'(ec_a), 32'd1);
    step(0, 1, 0, 2'b00, 0);
    chk("t6_restart_vec", 32'(vc_a), 32'd0);
    chk("t6_restart_err", 32'(ec_a), 32'd0);
    chk("t6_restart_ffv", 32'(ffv_a), 32'd0);
    step(0, 0, 1, 2'b11, 0);
    step(0, 0, 1, 2'b10, 1);
    step(0, 0, 1, 2'b01, 1);
    push(0, 1, 0, 8'd4, 8'd0, 4'hF, 0, 2'b00, cyc + 1);
    step(0, 0, 1, 2'b00, 1);
    wait_done(0, "t6_done", 20);

    // T5: 255 wrong samples on the long instance, timeout disabled
    tt = T_AND;
    tbl = T_AND;
    step(1, 1, 0, 2'b00, 0);
    idle(300);
    chk("t5_no_timeout_busy", 32'(busy_b), 32'd1);
    chk("t5_no_timeout_flag", 32'(tmo_b), 32'd0);
    for (int i = 0; i < 255; i++) begin
      idx = 2'(i + 1);
      if (i == 254) push(1, 0, 0, 8'hFF, 8'hFF, 4'hF, 1, 2'b01, cyc + 1);
      step(1, 0, 1, idx, ~tbl[idx]);
    end
    wait_done(1, "t5_done", 20);
    chk("t5_a_untouched", 32'(vc_a), 32'd4);

    idle(3);
    chk("scoreboard_a_drained", q_a.size(), 32'd0);
    chk("scoreboard_b_drained", q_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
